// File: rtl/rvfi_dmem_multi_check_if.sv
// RVFI data-memory retirement bundle for NRET channels. The core side drives it;
// checkers observe it.
interface rvfi_dmem_multi_check_if #(
  parameter int XLEN = 32,
  parameter int NRET = 1
);
  logic [NRET-1:0]        rvfi_valid;
  logic [NRET*XLEN-1:0]   rvfi_mem_addr;
  logic [NRET*XLEN/8-1:0] rvfi_mem_rmask;
  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask;
  logic [NRET*XLEN-1:0]   rvfi_mem_rdata;
  logic [NRET*XLEN-1:0]   rvfi_mem_wdata;

  modport master (
    output rvfi_valid,
    output rvfi_mem_addr,
    output rvfi_mem_rmask,
    output rvfi_mem_wmask,
    output rvfi_mem_rdata,
    output rvfi_mem_wdata
  );

  modport slave (
    input rvfi_valid,
    input rvfi_mem_addr,
    input rvfi_mem_rmask,
    input rvfi_mem_wmask,
    input rvfi_mem_rdata,
    input rvfi_mem_wdata
  );
endinterface

// File: rtl/rvfi_dmem_multi_check.sv
// Data-memory consistency checker: shadows DEPTH aligned words from a latched base,
// checks every retired read byte against the latest write, and records the first mismatch.
module rvfi_dmem_multi_check #(
  parameter int XLEN  = 32,
  parameter int NRET  = 1,
  parameter int DEPTH = 4,
  parameter int LEARN = 0,
  localparam int BW   = XLEN / 8,
  localparam int LB   = $clog2(BW),
  localparam int CHW  = (NRET > 1) ? $clog2(NRET) : 1,
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [XLEN-1:0]        base_addr,
  rvfi_dmem_multi_check_if.slave rvfi,
  output logic                   err,
  output logic [CHW-1:0]         err_chan,
  output logic [IDXW-1:0]        err_idx,
  output logic [LB-1:0]          err_byte,
  output logic [15:0]            check_cnt
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(BW - 1);
  localparam logic [XLEN-1:0] DEPTH_W    = XLEN'(DEPTH);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("rvfi_dmem_multi_check: XLEN must be 32 or 64");
    end
    if (DEPTH < 1 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rvfi_dmem_multi_check: DEPTH must be a power of two in 1..64");
    end
    if (NRET < 1) begin : g_bad_nret
      $error("rvfi_dmem_multi_check: NRET must be at least 1");
    end
  endgenerate

  // Clamp the comparison counter at all-ones instead of wrapping.
  function automatic logic [15:0] sat_cnt(input logic [15:0] cur, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {17'd0, cur} + {1'b0, inc};
    return (sum > 33'h0_0000_FFFF) ? 16'hFFFF : sum[15:0];
  endfunction

  logic [7:0]      shadow_p1  [DEPTH][BW];
  logic [BW-1:0]   written_p1 [DEPTH];
  logic [XLEN-1:0] base_q;
  logic            base_vld;

  logic [7:0]      shadow_p0  [DEPTH][BW];
  logic [BW-1:0]   written_p0 [DEPTH];
  logic            err_p0;
  logic [CHW-1:0]  err_chan_p0;
  logic [IDXW-1:0] err_idx_p0;
  logic [LB-1:0]   err_byte_p0;
  logic [31:0]     add_p0;

  logic [XLEN-1:0] addr_c;
  logic [XLEN-1:0] idx_full;
  logic            hit_c;
  logic [IDXW-1:0] idx_c;
  logic [7:0]      rbyte;
  logic [7:0]      wbyte;

  // Stage p0: walk the channels in order so earlier writes feed later reads this cycle.
  always_comb begin
    shadow_p0   = shadow_p1;
    written_p0  = written_p1;
    err_p0      = err;
    err_chan_p0 = err_chan;
    err_idx_p0  = err_idx;
    err_byte_p0 = err_byte;
    add_p0      = '0;
    addr_c      = '0;
    idx_full    = '0;
    hit_c       = 1'b0;
    idx_c       = '0;
    rbyte       = '0;
    wbyte       = '0;
    for (int c = 0; c < NRET; c++) begin
      addr_c   = rvfi.rvfi_mem_addr[c*XLEN +: XLEN];
      // Unsigned full-width difference: addresses below the base wrap to huge values and miss.
      idx_full = (addr_c >> LB) - (base_q >> LB);
      hit_c    = rvfi.rvfi_valid[c] && base_vld && (idx_full < DEPTH_W);
      idx_c    = idx_full[IDXW-1:0];
      if (hit_c) begin
        for (int i = 0; i < BW; i++) begin
          rbyte = rvfi.rvfi_mem_rdata[c*XLEN + i*8 +: 8];
          if (rvfi.rvfi_mem_rmask[c*BW + i]) begin
            if (written_p0[idx_c][i]) begin
              add_p0 = add_p0 + 32'd1;
              if (!err_p0 && (shadow_p0[idx_c][i] != rbyte)) begin
                err_p0      = 1'b1;
                err_chan_p0 = CHW'(c);
                err_idx_p0  = idx_c;
                err_byte_p0 = LB'(i);
              end
            end else if (LEARN != 0) begin
              shadow_p0[idx_c][i]  = rbyte;
              written_p0[idx_c][i] = 1'b1;
            end
          end
        end
        // The channel's own write lands only after its read has been checked.
        for (int i = 0; i < BW; i++) begin
          wbyte = rvfi.rvfi_mem_wdata[c*XLEN + i*8 +: 8];
          if (rvfi.rvfi_mem_wmask[c*BW + i]) begin
            shadow_p0[idx_c][i]  = wbyte;
            written_p0[idx_c][i] = 1'b1;
          end
        end
      end
    end
  end

  // Stage p1: control state and outputs, cleared by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      base_vld   <= 1'b0;
      written_p1 <= '{default: '0};
      err        <= 1'b0;
      err_chan   <= '0;
      err_idx    <= '0;
      err_byte   <= '0;
      check_cnt  <= '0;
    end else begin
      base_vld   <= 1'b1;
      written_p1 <= written_p0;
      err        <= err_p0;
      err_chan   <= err_chan_p0;
      err_idx    <= err_idx_p0;
      err_byte   <= err_byte_p0;
      check_cnt  <= sat_cnt(check_cnt, add_p0);
    end
  end

  // Shadow bytes and base are data: never reset, only qualified by written/base_vld.
  always_ff @(posedge clk) begin
    shadow_p1 <= shadow_p0;
    if (resetn && !base_vld) begin
      base_q <= base_addr & ALIGN_MASK;
    end
  end

endmodule

// File: tb/tb_rvfi_dmem_multi_check.sv
// Bench for rvfi_dmem_multi_check: directed vector table, hand sequences for
// LEARN/reset/wrap/priority, and randomized traffic against a byte-map reference model.
`timescale 1ns/1ps
module tb_rvfi_dmem_multi_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a, rstn_b;
  logic [31:0] base_a, base_b;

  rvfi_dmem_multi_check_if #(.XLEN(32), .NRET(2)) ifa ();
  rvfi_dmem_multi_check_if #(.XLEN(32), .NRET(1)) ifb ();

  logic        err_a, err_b;
  logic        chan_a, chan_b;
  logic [1:0]  idx_a, idx_b, byte_a, byte_b;
  logic [15:0] cnt_a, cnt_b;

  rvfi_dmem_multi_check #(.XLEN(32), .NRET(2), .DEPTH(4), .LEARN(0)) dut_a (
    .clk(clk), .resetn(rstn_a), .base_addr(base_a), .rvfi(ifa),
    .err(err_a), .err_chan(chan_a), .err_idx(idx_a), .err_byte(byte_a), .check_cnt(cnt_a)
  );

  rvfi_dmem_multi_check #(.XLEN(32), .NRET(1), .DEPTH(4), .LEARN(1)) dut_b (
    .clk(clk), .resetn(rstn_b), .base_addr(base_b), .rvfi(ifb),
    .err(err_b), .err_chan(chan_b), .err_idx(idx_b), .err_byte(byte_b), .check_cnt(cnt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] a0; logic [3:0] rm0; logic [3:0] wm0; logic [31:0] rd0; logic [31:0] wd0;
    logic [31:0] a1; logic [3:0] rm1; logic [3:0] wm1; logic [31:0] rd1; logic [31:0] wd1;
    logic        e_err; logic e_chan; logic [1:0] e_idx; logic [1:0] e_byte; logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic e_err, input logic e_chan,
                       input logic [1:0] e_idx, input logic [1:0] e_byte, input logic [15:0] e_cnt);
    chk({nm, ".err"},  {31'd0, err_a},  {31'd0, e_err});
    chk({nm, ".chan"}, {31'd0, chan_a}, {31'd0, e_chan});
    chk({nm, ".idx"},  {30'd0, idx_a},  {30'd0, e_idx});
    chk({nm, ".byte"}, {30'd0, byte_a}, {30'd0, e_byte});
    chk({nm, ".cnt"},  {16'd0, cnt_a},  {16'd0, e_cnt});
  endtask

  task automatic chk_b(input string nm, input logic e_err,
                       input logic [1:0] e_idx, input logic [1:0] e_byte, input logic [15:0] e_cnt);
    chk({nm, ".err"},  {31'd0, err_b},  {31'd0, e_err});
    chk({nm, ".chan"}, {31'd0, chan_b}, 32'd0);
    chk({nm, ".idx"},  {30'd0, idx_b},  {30'd0, e_idx});
    chk({nm, ".byte"}, {30'd0, byte_b}, {30'd0, e_byte});
    chk({nm, ".cnt"},  {16'd0, cnt_b},  {16'd0, e_cnt});
  endtask

  task automatic idle_a();
    ifa.rvfi_valid = '0; ifa.rvfi_mem_addr = '0; ifa.rvfi_mem_rmask = '0;
    ifa.rvfi_mem_wmask = '0; ifa.rvfi_mem_rdata = '0; ifa.rvfi_mem_wdata = '0;
  endtask

  task automatic idle_b();
    ifb.rvfi_valid = '0; ifb.rvfi_mem_addr = '0; ifb.rvfi_mem_rmask = '0;
    ifb.rvfi_mem_wmask = '0; ifb.rvfi_mem_rdata = '0; ifb.rvfi_mem_wdata = '0;
  endtask

  task automatic drive_a(input logic [1:0] v,
                         input logic [31:0] a0, input logic [3:0] rm0, input logic [3:0] wm0,
                         input logic [31:0] rd0, input logic [31:0] wd0,
                         input logic [31:0] a1, input logic [3:0] rm1, input logic [3:0] wm1,
                         input logic [31:0] rd1, input logic [31:0] wd1);
    ifa.rvfi_valid = v;
    ifa.rvfi_mem_addr = {a1, a0};
    ifa.rvfi_mem_rmask = {rm1, rm0};
    ifa.rvfi_mem_wmask = {wm1, wm0};
    ifa.rvfi_mem_rdata = {rd1, rd0};
    ifa.rvfi_mem_wdata = {wd1, wd0};
    tick();
    idle_a();
  endtask

  task automatic drive_b(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] rd, input logic [31:0] wd);
    ifb.rvfi_valid = 1'b1; ifb.rvfi_mem_addr = a; ifb.rvfi_mem_rmask = rm;
    ifb.rvfi_mem_wmask = wm; ifb.rvfi_mem_rdata = rd; ifb.rvfi_mem_wdata = wd;
    tick();
    idle_b();
  endtask

  task automatic reset_a(input logic [31:0] base);
    rstn_a = 1'b0;
    base_a = base;
    tick();
    chk_a("rst_a", 1'b0, 1'b0, 2'd0, 2'd0, 16'd0);
    rstn_a = 1'b1;
    tick();
  endtask

  function automatic vec_t mk(input logic [1:0] v,
                              input logic [31:0] a0, input logic [3:0] rm0, input logic [3:0] wm0,
                              input logic [31:0] rd0, input logic [31:0] wd0,
                              input logic [31:0] a1, input logic [3:0] rm1, input logic [3:0] wm1,
                              input logic [31:0] rd1, input logic [31:0] wd1,
                              input logic e_err, input logic e_chan, input logic [1:0] e_idx,
                              input logic [1:0] e_byte, input logic [15:0] e_cnt);
    vec_t t;
    t.v = v; t.a0 = a0; t.rm0 = rm0; t.wm0 = wm0; t.rd0 = rd0; t.wd0 = wd0;
    t.a1 = a1; t.rm1 = rm1; t.wm1 = wm1; t.rd1 = rd1; t.wd1 = wd1;
    t.e_err = e_err; t.e_chan = e_chan; t.e_idx = e_idx; t.e_byte = e_byte; t.e_cnt = e_cnt;
    return t;
  endfunction

  // Reference model: byte-addressed map of the most recent write per byte.
  bit [7:0]    m_mem [bit [31:0]];
  logic        m_err;
  logic        m_chan;
  logic [1:0]  m_idx, m_byte;
  int          m_cnt;
  logic [31:0] m_base;

  initial begin
    rstn_a = 1'b0; rstn_b = 1'b0;
    base_a = 32'h1000; base_b = 32'h1000;
    idle_a(); idle_b();
    tick(); tick();
    chk_a("init_a", 1'b0, 1'b0, 2'd0, 2'd0, 16'd0);
    chk_b("init_b", 1'b0, 2'd0, 2'd0, 16'd0);
    rstn_a = 1'b1; rstn_b = 1'b1;
    tick();

    tbl[0] = mk(2'b01, 32'h1004, 4'h0, 4'hF, 32'h0, 32'hDEADBEEF, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                1'b0, 1'b0, 2'd0, 2'd0, 16'd0);
    tbl[1] = mk(2'b01, 32'h1004, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                1'b0, 1'b0, 2'd0, 2'd0, 16'd4);
    tbl[2] = mk(2'b11, 32'h1000, 4'h0, 4'hF, 32'h0, 32'h11223344, 32'h1000, 4'hF, 4'h0, 32'h11223344, 32'h0,
                1'b0, 1'b0, 2'd0, 2'd0, 16'd8);
    tbl[3] = mk(2'b11, 32'h0FFC, 4'hF, 4'hF, 32'h99999999, 32'h0, 32'h1010, 4'hF, 4'hF, 32'h77777777, 32'h55555555,
                1'b0, 1'b0, 2'd0, 2'd0, 16'd8);
    tbl[4] = mk(2'b11, 32'h1000, 4'hF, 4'h0, 32'h11223344, 32'h0, 32'h1004, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0,
                1'b0, 1'b0, 2'd0, 2'd0, 16'd16);
    tbl[5] = mk(2'b01, 32'h100C, 4'h0, 4'h1, 32'h0, 32'h000000AA, 32'h1000, 4'hF, 4'h0, 32'h0, 32'h0,
                1'b0, 1'b0, 2'd0, 2'd0, 16'd16);
    tbl[6] = mk(2'b01, 32'h100C, 4'h1, 4'h0, 32'h000000AB, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                1'b1, 1'b0, 2'd3, 2'd0, 16'd17);
    tbl[7] = mk(2'b10, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h1004, 4'hF, 4'h0, 32'h0, 32'h0,
                1'b1, 1'b0, 2'd3, 2'd0, 16'd21);

    for (int r = 0; r < 8; r++) begin
      drive_a(tbl[r].v, tbl[r].a0, tbl[r].rm0, tbl[r].wm0, tbl[r].rd0, tbl[r].wd0,
              tbl[r].a1, tbl[r].rm1, tbl[r].wm1, tbl[r].rd1, tbl[r].wd1);
      chk_a($sformatf("vec%0d", r), tbl[r].e_err, tbl[r].e_chan, tbl[r].e_idx, tbl[r].e_byte, tbl[r].e_cnt);
    end

    // After reset nothing is known: reads before writes are not checked.
    reset_a(32'h1000);
    drive_a(2'b01, 32'h1004, 4'hF, 4'h0, 32'h12345678, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    chk_a("post_rst_read", 1'b0, 1'b0, 2'd0, 2'd0, 16'd0);
    drive_a(2'b01, 32'h1008, 4'hF, 4'h0, 32'hCAFEF00D, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    drive_a(2'b01, 32'h1008, 4'hF, 4'h0, 32'hCAFEF00E, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    chk_a("nolearn", 1'b0, 1'b0, 2'd0, 2'd0, 16'd0);
    drive_a(2'b11, 32'h1000, 4'h0, 4'hF, 32'h0, 32'h11223344, 32'h1000, 4'hF, 4'h0, 32'h11223345, 32'h0);
    chk_a("fwd_mismatch", 1'b1, 1'b1, 2'd0, 2'd0, 16'd4);

    // Lowest channel, then lowest byte wins among simultaneous mismatches.
    reset_a(32'h1000);
    drive_a(2'b01, 32'h1004, 4'h0, 4'hF, 32'h0, 32'h00000000, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    drive_a(2'b11, 32'h1004, 4'hF, 4'h0, 32'h00FFFF00, 32'h0, 32'h1004, 4'hF, 4'h0, 32'hFFFFFFFF, 32'h0);
    chk_a("priority", 1'b1, 1'b0, 2'd1, 2'd1, 16'd8);

    // Window at the top of the address space: 0xFFFFFFFC hits, 0x00000000 misses.
    reset_a(32'hFFFFFFF8);
    drive_a(2'b11, 32'hFFFFFFFC, 4'h0, 4'hF, 32'h0, 32'hA5A5A5A5, 32'h00000000, 4'h0, 4'hF, 32'h0, 32'h01020304);
    drive_a(2'b11, 32'hFFFFFFFC, 4'hF, 4'h0, 32'hA5A5A5A5, 32'h0, 32'h00000000, 4'hF, 4'h0, 32'hFFFFFFFF, 32'h0);
    chk_a("wrap", 1'b0, 1'b0, 2'd0, 2'd0, 16'd4);

    // LEARN=1 instance.
    drive_b(32'h1008, 4'hF, 4'h0, 32'hCAFEF00D, 32'h0);
    chk_b("learn_seed", 1'b0, 2'd0, 2'd0, 16'd0);
    drive_b(32'h1008, 4'hF, 4'h0, 32'hCAFEF00E, 32'h0);
    chk_b("learn_mis", 1'b1, 2'd2, 2'd0, 16'd4);
    drive_b(32'h1008, 4'hF, 4'h0, 32'h00FEF00D, 32'h0);
    chk_b("learn_frozen", 1'b1, 2'd2, 2'd0, 16'd8);
    rstn_b = 1'b0;
    tick();
    chk_b("rst_b", 1'b0, 2'd0, 2'd0, 16'd0);
    rstn_b = 1'b1;
    tick();
    drive_b(32'h1008, 4'hF, 4'h0, 32'h12345678, 32'h0);
    chk_b("rst_b_read", 1'b0, 2'd0, 2'd0, 16'd0);
    drive_b(32'h1008, 4'hF, 4'h0, 32'h12345678, 32'h0);
    chk_b("rst_b_reread", 1'b0, 2'd0, 2'd0, 16'd4);

    // Randomized traffic on the two-channel instance.
    for (int k = 0; k < 600; k++) begin
      logic [1:0]  v;
      logic [31:0] a [2];
      logic [3:0]  rm [2];
      logic [3:0]  wm [2];
      logic [31:0] rd [2];
      logic [31:0] wd [2];
      if (k % 150 == 0) begin
        reset_a(32'h2000 | 32'($urandom_range(0, 3)));
        m_mem.delete();
        m_err = 1'b0; m_chan = 1'b0; m_idx = 2'd0; m_byte = 2'd0; m_cnt = 0;
        m_base = base_a & 32'hFFFFFFFC;
      end
      v = 2'($urandom_range(0, 3));
      for (int c = 0; c < 2; c++) begin
        logic [31:0] aw, bw, ba;
        a[c]  = m_base + 32'($urandom_range(0, 7)) * 32'd4 - 32'd8 + 32'($urandom_range(0, 3));
        rm[c] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        wm[c] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        wd[c] = $urandom;
        rd[c] = $urandom;
        aw = a[c] >> 2;
        bw = m_base >> 2;
        for (int i = 0; i < 4; i++) begin
          ba = {aw[29:0], 2'b00} + 32'(i);
          if (m_mem.exists(ba) && $urandom_range(0, 39) != 0) rd[c][i*8 +: 8] = m_mem[ba];
        end
        if (v[c] && aw >= bw && (aw - bw) < 32'd4) begin
          for (int i = 0; i < 4; i++) begin
            ba = {aw[29:0], 2'b00} + 32'(i);
            if (rm[c][i] && m_mem.exists(ba)) begin
              m_cnt++;
              if (!m_err && m_mem[ba] != rd[c][i*8 +: 8]) begin
                m_err = 1'b1; m_chan = 1'(c); m_idx = 2'(aw - bw); m_byte = 2'(i);
              end
            end
          end
          for (int i = 0; i < 4; i++) begin
            ba = {aw[29:0], 2'b00} + 32'(i);
            if (wm[c][i]) m_mem[ba] = wd[c][i*8 +: 8];
          end
        end
      end
      drive_a(v, a[0], rm[0], wm[0], rd[0], wd[0], a[1], rm[1], wm[1], rd[1], wd[1]);
      chk_a($sformatf("rnd%0d", k), m_err, m_chan, m_idx, m_byte,
            (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
